// File: rtl/ascii_sep_ctrl.sv
// rtl/ascii_sep_ctrl.sv - ASCII number-separation session controller
module ascii_sep_ctrl #(
  parameter int MAX_PAYLOAD    = 2048,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  up_payload_data,
  input  logic        up_payload_valid,
  input  logic        up_payload_last,
  output logic        up_payload_ready,
  output logic [7:0]  val_payload_data,
  output logic        val_payload_valid,
  output logic        val_payload_last,
  input  logic        val_payload_ready,
  input  logic        val_done,
  input  logic        val_invalid,
  input  logic [15:0] val_length,
  output logic        val_rst_n,
  output logic        parse_start,
  output logic [15:0] parse_length,
  input  logic        parse_done,
  input  logic        parse_error,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [2:0]  result_code,
  output logic [15:0] result_length,
  output logic        busy
);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   MAX_LEN  = 16'(MAX_PAYLOAD);

  localparam logic [2:0] CODE_OK        = 3'd0;
  localparam logic [2:0] CODE_INVALID   = 3'd1;
  localparam logic [2:0] CODE_PARSE_ERR = 3'd2;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd3;
  localparam logic [2:0] CODE_OVERFLOW  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DRAIN, S_WAIT_VAL, S_PARSE, S_REPORT, S_CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          val_rst_n_q, val_rst_n_d;
  logic          parse_start_q, parse_start_d;
  logic [15:0]   parse_length_q, parse_length_d;
  logic          result_valid_q, result_valid_d;
  logic [2:0]    result_code_q, result_code_d;
  logic [15:0]   result_length_q, result_length_d;

  logic fwd, drain, xfer, drained, activity, tmo_hit, counting;

  // Zero-latency pass-through to the validator while receiving; drain swallows bytes
  always_comb begin
    fwd               = (state_q == S_IDLE) || (state_q == S_RECV);
    drain             = (state_q == S_DRAIN);
    val_payload_data  = up_payload_data;
    val_payload_last  = up_payload_last;
    val_payload_valid = up_payload_valid & fwd;
    up_payload_ready  = (val_payload_ready & fwd) | drain;
    xfer              = up_payload_valid & val_payload_ready & fwd;
    drained           = up_payload_valid & drain;
    activity          = xfer | drained;
    tmo_hit           = (tmo_q == TMO_LAST);
    counting          = (state_q == S_RECV) || (state_q == S_DRAIN) ||
                        (state_q == S_WAIT_VAL) || (state_q == S_PARSE);
  end

  // Next-state logic; done events are checked before the timeout so they win a tie
  always_comb begin
    state_d        = state_q;
    result_code_d  = result_code_q;
    parse_start_d  = 1'b0;
    parse_length_d = parse_length_q;
    case (state_q)
      S_IDLE, S_RECV: begin
        if (xfer) begin
          if (up_payload_last) begin
            state_d = S_WAIT_VAL;
          end else if (byte_cnt_q + 16'd1 == MAX_LEN) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RECV;
          end
        end else if ((state_q == S_RECV) && tmo_hit) begin
          state_d       = S_REPORT;
          result_code_d = CODE_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (drained && up_payload_last) begin
          state_d       = S_REPORT;
          result_code_d = CODE_OVERFLOW;
        end else if (!drained && tmo_hit) begin
          state_d       = S_REPORT;
          result_code_d = CODE_TIMEOUT;
        end
      end
      S_WAIT_VAL: begin
        if (val_done) begin
          if (val_invalid) begin
            state_d       = S_REPORT;
            result_code_d = CODE_INVALID;
          end else begin
            state_d        = S_PARSE;
            parse_start_d  = 1'b1;
            parse_length_d = val_length;
          end
        end else if (tmo_hit) begin
          state_d       = S_REPORT;
          result_code_d = CODE_TIMEOUT;
        end
      end
      S_PARSE: begin
        if (parse_done) begin
          state_d       = S_REPORT;
          result_code_d = parse_error ? CODE_PARSE_ERR : CODE_OK;
        end else if (tmo_hit) begin
          state_d       = S_REPORT;
          result_code_d = CODE_TIMEOUT;
        end
      end
      S_REPORT: begin
        if (result_ready) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte and inactivity counters plus registered result/clear outputs
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      byte_cnt_d = '0;
    end else if (activity) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end
    tmo_d = '0;
    if ((state_d == state_q) && !activity && counting) begin
      tmo_d = tmo_q + 1'b1;
    end
    result_length_d = result_length_q;
    if ((state_d == S_REPORT) && (state_q != S_REPORT)) begin
      result_length_d = byte_cnt_d;
    end
    result_valid_d = (state_d == S_REPORT);
    val_rst_n_d    = (state_d != S_CLEAR);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      byte_cnt_q      <= '0;
      tmo_q           <= '0;
      val_rst_n_q     <= 1'b1;
      parse_start_q   <= 1'b0;
      parse_length_q  <= '0;
      result_valid_q  <= 1'b0;
      result_code_q   <= CODE_OK;
      result_length_q <= '0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      tmo_q           <= tmo_d;
      val_rst_n_q     <= val_rst_n_d;
      parse_start_q   <= parse_start_d;
      parse_length_q  <= parse_length_d;
      result_valid_q  <= result_valid_d;
      result_code_q   <= result_code_d;
      result_length_q <= result_length_d;
    end
  end

  assign val_rst_n     = val_rst_n_q;
  assign parse_start   = parse_start_q;
  assign parse_length  = parse_length_q;
  assign result_valid  = result_valid_q;
  assign result_code   = result_code_q;
  assign result_length = result_length_q;
  assign busy          = (state_q != S_IDLE);

endmodule
